// File: rtl/trena_pkg.sv
// Shared definitions for the trena measurement scheduler: state encodings,
// default timing constants and the measurement width.
package trena_pkg;

  localparam int MEDIDA_W = 12;

  // 500 ms and 50 ms at a 50 MHz clock
  localparam int PERIODO_PADRAO = 25_000_000;
  localparam int TIMEOUT_PADRAO = 2_500_000;

  localparam logic [3:0] FALHAS_MAX = 4'd15;

  localparam logic [3:0] E_INICIAL  = 4'd0;
  localparam logic [3:0] E_ESPERA   = 4'd1;
  localparam logic [3:0] E_DISPARA  = 4'd2;
  localparam logic [3:0] E_AGUARDA  = 4'd3;
  localparam logic [3:0] E_REGISTRA = 4'd4;
  localparam logic [3:0] E_FALHA    = 4'd5;

  typedef enum logic [3:0] {
    INICIAL  = E_INICIAL,
    ESPERA   = E_ESPERA,
    DISPARA  = E_DISPARA,
    AGUARDA  = E_AGUARDA,
    REGISTRA = E_REGISTRA,
    FALHA    = E_FALHA
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Mod-M up-counter with a clear input (zera), an enable (conta) and a
// terminal flag (fim) raised while the count equals M-1. The count holds at
// M-1 instead of wrapping; the owner is expected to clear it.
module contador_m #(
  parameter int M = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  assign fim = (valor_q == ULTIMO);

  // Next count: clear has priority, otherwise advance until the terminal value
  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && !fim) begin
      valor_d = valor_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule

// File: rtl/trena_agendador.sv
// Scheduler/supervisor for the ultrasonic tape measure: issues periodic or
// manual measurement requests, waits for completion, latches the BCD result
// and recovers from missing echoes with a timeout and a trena reset pulse.
module trena_agendador
  import trena_pkg::*;
#(
  parameter int PERIODO = PERIODO_PADRAO,
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic                mensurar_manual,
  input  logic                pronto_trena,
  input  logic [MEDIDA_W-1:0] medida_in,
  output logic                mensurar,
  output logic                reset_trena,
  output logic [MEDIDA_W-1:0] medida,
  output logic                medida_valida,
  output logic                timeout,
  output logic [3:0]          contagem_falhas,
  output logic [3:0]          db_estado
);

  estado_t estado_q, estado_d;

  logic manual_prev_q, manual_prev_d;
  logic pronto_prev_q, pronto_prev_d;

  logic [MEDIDA_W-1:0] captura_q, captura_d;
  logic [MEDIDA_W-1:0] medida_q, medida_d;
  logic                timeout_q, timeout_d;
  logic [3:0]          falhas_q, falhas_d;

  logic borda_manual;
  logic borda_pronto;

  logic zera_periodo, conta_periodo, fim_periodo;
  logic zera_timeout, conta_timeout, fim_timeout;

  assign borda_manual = mensurar_manual & ~manual_prev_q;
  assign borda_pronto = pronto_trena & ~pronto_prev_q;

  assign medida          = medida_q;
  assign timeout         = timeout_q;
  assign contagem_falhas = falhas_q;
  assign db_estado       = estado_q;

  contador_m #(.M(PERIODO)) u_intervalo (
    .clock (clock),
    .reset (reset),
    .zera  (zera_periodo),
    .conta (conta_periodo),
    .fim   (fim_periodo)
  );

  contador_m #(.M(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timeout),
    .conta (conta_timeout),
    .fim   (fim_timeout)
  );

  // Previous-value registers follow their inputs every cycle for edge detection
  always_comb begin
    manual_prev_d = mensurar_manual;
    pronto_prev_d = pronto_trena;
  end

  // Next state, counter control, result latching and the one-cycle pulses
  always_comb begin
    estado_d      = estado_q;
    captura_d     = captura_q;
    medida_d      = medida_q;
    timeout_d     = timeout_q;
    falhas_d      = falhas_q;
    mensurar      = 1'b0;
    reset_trena   = 1'b0;
    medida_valida = 1'b0;
    zera_periodo  = 1'b1;
    conta_periodo = 1'b0;
    zera_timeout  = 1'b1;
    conta_timeout = 1'b0;

    case (estado_q)
      INICIAL: begin
        estado_d = ESPERA;
      end

      ESPERA: begin
        zera_periodo  = ~ligar;
        conta_periodo = ligar;
        if ((ligar && fim_periodo) || borda_manual) begin
          zera_periodo = 1'b1;
          estado_d     = DISPARA;
        end
      end

      DISPARA: begin
        mensurar = 1'b1;
        estado_d = AGUARDA;
      end

      AGUARDA: begin
        zera_timeout  = 1'b0;
        conta_timeout = 1'b1;
        if (borda_pronto) begin
          captura_d = medida_in;
          estado_d  = REGISTRA;
        end else if (fim_timeout) begin
          estado_d = FALHA;
        end
      end

      REGISTRA: begin
        medida_valida = 1'b1;
        medida_d      = captura_q;
        timeout_d     = 1'b0;
        estado_d      = ESPERA;
      end

      FALHA: begin
        reset_trena = 1'b1;
        timeout_d   = 1'b1;
        if (falhas_q != FALHAS_MAX) begin
          falhas_d = falhas_q + 4'd1;
        end
        estado_d = ESPERA;
      end

      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= INICIAL;
      manual_prev_q <= 1'b0;
      pronto_prev_q <= 1'b0;
      captura_q     <= '0;
      medida_q      <= '0;
      timeout_q     <= 1'b0;
      falhas_q      <= 4'd0;
    end else begin
      estado_q      <= estado_d;
      manual_prev_q <= manual_prev_d;
      pronto_prev_q <= pronto_prev_d;
      captura_q     <= captura_d;
      medida_q      <= medida_d;
      timeout_q     <= timeout_d;
      falhas_q      <= falhas_d;
    end
  end

endmodule

// File: tb/tb_trena_agendador.sv
// Testbench for trena_agendador: directed stimulus pushes expected pulses
// (kind, cycle and resulting register values) into a queue; a monitor pops
// and compares each time the DUT emits mensurar, medida_valida or reset_trena.
module tb_trena_agendador;

  localparam int PERIODO = 20;
  localparam int TIMEOUT = 8;

  localparam int K_MENSURAR = 0;
  localparam int K_VALIDA   = 1;
  localparam int K_RESET    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ligar;
  logic        mensurar_manual;
  logic        pronto_trena;
  logic [11:0] medida_in;
  logic        mensurar;
  logic        reset_trena;
  logic [11:0] medida;
  logic        medida_valida;
  logic        timeout;
  logic [3:0]  contagem_falhas;
  logic [3:0]  db_estado;

  int cyc = 0;
  int n_compared = 0;
  int n_failed = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [11:0] medida;
    logic        timeout;
    logic [3:0]  falhas;
  } ev_t;

  ev_t exp_q[$];

  logic [11:0] exp_medida;
  logic        exp_timeout;
  logic [3:0]  exp_falhas;

  logic pend = 1'b0;
  ev_t  pend_ev;

  trena_agendador #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT)) dut (
    .clock           (clock),
    .reset           (reset),
    .ligar           (ligar),
    .mensurar_manual (mensurar_manual),
    .pronto_trena    (pronto_trena),
    .medida_in       (medida_in),
    .mensurar        (mensurar),
    .reset_trena     (reset_trena),
    .medida          (medida),
    .medida_valida   (medida_valida),
    .timeout         (timeout),
    .contagem_falhas (contagem_falhas),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic m, input logic p, input logic [11:0] v);
    ligar           = l;
    mensurar_manual = m;
    pronto_trena    = p;
    medida_in       = v;
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pushEv(input int kind, input int c);
    ev_t ev;
    ev.kind    = kind;
    ev.cyc     = c;
    ev.medida  = exp_medida;
    ev.timeout = exp_timeout;
    ev.falhas  = exp_falhas;
    exp_q.push_back(ev);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_mensurar", 32'(mensurar), 32'd0);
    checkOutput("rst_reset_trena", 32'(reset_trena), 32'd0);
    checkOutput("rst_medida", 32'(medida), 32'd0);
    checkOutput("rst_medida_valida", 32'(medida_valida), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_falhas", 32'(contagem_falhas), 32'd0);
    checkOutput("rst_db_estado", 32'(db_estado), 32'd0);
  endtask

  // Drive pronto "delay" cycles after the request in cycle d; returns next ESPERA cycle
  task automatic measure(input int d, input int delay, input logic [11:0] val, output int e_next);
    waitCycle(d + delay);
    applyStimulus(ligar, mensurar_manual, 1'b1, val);
    exp_medida  = val;
    exp_timeout = 1'b0;
    pushEv(K_VALIDA, d + delay + 1);
    @(negedge clock);
    applyStimulus(ligar, mensurar_manual, 1'b0, ~val);
    e_next = d + delay + 2;
  endtask

  // Manual edge issued now (state ESPERA); returns the DISPARA cycle
  task automatic manualReq(output int d);
    d = cyc + 1;
    pushEv(K_MENSURAR, d);
    applyStimulus(ligar, 1'b1, pronto_trena, medida_in);
    @(negedge clock);
    applyStimulus(ligar, 1'b0, pronto_trena, medida_in);
  endtask

  // Manual request that is never answered; returns next ESPERA cycle
  task automatic timeoutReq(output int e_next);
    int d;
    manualReq(d);
    exp_timeout = 1'b1;
    if (exp_falhas != 4'd15) exp_falhas = exp_falhas + 4'd1;
    pushEv(K_RESET, d + TIMEOUT + 1);
    waitCycle(d + TIMEOUT + 1);
    e_next = d + TIMEOUT + 2;
  endtask

  task automatic handlePulse(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      checkOutput("pulse_kind", 32'(kind), 32'(ev.kind));
      checkOutput("pulse_cycle", 32'(cyc), 32'(ev.cyc));
      if (kind != K_MENSURAR) begin
        pend    = 1'b1;
        pend_ev = ev;
      end
    end
  endtask

  // Monitor: registered results are checked the cycle after their pulse
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (pend) begin
        checkOutput("medida_after_pulse", 32'(medida), 32'(pend_ev.medida));
        checkOutput("timeout_after_pulse", 32'(timeout), 32'(pend_ev.timeout));
        checkOutput("falhas_after_pulse", 32'(contagem_falhas), 32'(pend_ev.falhas));
        pend = 1'b0;
      end
      if (!reset) begin
        if (mensurar || reset_trena)
          checkOutput("pulse_exclusive", 32'(mensurar & reset_trena), 32'd0);
        if (mensurar)      handlePulse(K_MENSURAR);
        if (medida_valida) handlePulse(K_VALIDA);
        if (reset_trena)   handlePulse(K_RESET);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int e, d, rel, hold_end;
    exp_medida  = 12'h000;
    exp_timeout = 1'b0;
    exp_falhas  = 4'd0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) @(negedge clock);
    checkResetOutputs();

    rel   = cyc;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h123);
    checkOutput("estado_inicial", 32'(db_estado), 32'd0);
    @(negedge clock);
    checkOutput("estado_espera", 32'(db_estado), 32'd1);
    e = rel + 1;

    $display("[TB] automatic mode");
    for (int k = 0; k < 2; k++) begin
      d = e + PERIODO;
      pushEv(K_MENSURAR, d);
      measure(d, 3, 12'h123, e);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, medida_in);

    $display("[TB] manual mode");
    waitCycle(e + 3);
    applyStimulus(1'b0, 1'b1, 1'b0, medida_in);
    d = e + 4;
    pushEv(K_MENSURAR, d);
    hold_end = e + 13;
    measure(d, 2, 12'h045, e);
    waitCycle(hold_end);
    applyStimulus(1'b0, 1'b0, 1'b0, medida_in);
    waitCycle(e + PERIODO + 10);
    checkOutput("manual_idle_estado", 32'(db_estado), 32'd1);

    $display("[TB] timeout and recovery");
    timeoutReq(e);
    waitCycle(e);
    manualReq(d);
    measure(d, 4, 12'h678, e);

    $display("[TB] failure counter saturation");
    for (int k = 0; k < 17; k++) begin
      waitCycle(e);
      timeoutReq(e);
    end
    waitCycle(e);
    checkOutput("falhas_saturadas", 32'(contagem_falhas), 32'd15);
    checkOutput("timeout_sticky", 32'(timeout), 32'd1);

    $display("[TB] collisions");
    applyStimulus(1'b1, 1'b0, 1'b0, medida_in);
    d = e + PERIODO;
    waitCycle(e + PERIODO - 1);
    applyStimulus(1'b1, 1'b1, 1'b0, medida_in);
    pushEv(K_MENSURAR, d);
    waitCycle(d + 1);
    applyStimulus(1'b1, 1'b0, 1'b0, medida_in);
    waitCycle(d + 3);
    applyStimulus(1'b1, 1'b1, 1'b0, medida_in);
    measure(d, TIMEOUT, 12'h9AB, e);
    applyStimulus(1'b0, 1'b0, 1'b0, medida_in);

    $display("[TB] reset during AGUARDA");
    waitCycle(e + 2);
    manualReq(d);
    waitCycle(d + 3);
    #3;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 12'hFFF);
    #1;
    checkResetOutputs();
    exp_medida  = 12'h000;
    exp_timeout = 1'b0;
    exp_falhas  = 4'd0;
    @(negedge clock);
    @(negedge clock);
    rel   = cyc;
    reset = 1'b0;
    checkOutput("estado_inicial_pos_reset", 32'(db_estado), 32'd0);
    @(negedge clock);
    checkOutput("estado_espera_pos_reset", 32'(db_estado), 32'd1);
    waitCycle(rel + PERIODO + 10);
    checkOutput("estado_final", 32'(db_estado), 32'd1);
    checkOutput("medida_final", 32'(medida), 32'd0);
    checkOutput("fila_vazia", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
